// File: rtl/apb_spi_prog_master.sv
// APB-programmable SPI master: CTRL/DIV/STATUS registers, TX/RX byte FIFOs and a
// LEAD/SHIFT/LAG shift engine with selectable CPOL, CPHA and bit order.
module apb_spi_prog_master #(
    parameter int APB_WIDTH  = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                 PCLK,
    input  logic                 PRESETN,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [7:0]           PADDR,
    input  logic [APB_WIDTH-1:0] PWDATA,
    output logic [APB_WIDTH-1:0] PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic                 IRQ_request,
    input  logic                 MISO,
    output logic                 MOSI,
    output logic                 SCK,
    output logic                 NSS
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_LAG} state_t;
    state_t state_q, state_d;

    logic [4:0]           ctrl_q, ctrl_d;
    logic [DIV_WIDTH-1:0] div_q, div_d, div_l_q, cnt_q;
    logic                 cpol_l_q, cpha_l_q, lsbf_l_q;
    logic                 done_q, done_d, ovr_q, ovr_d, irq_q;
    logic                 sck_q, nss_q, mosi_q, rx_push_q;
    logic [3:0]           edge_q;
    logic [7:0]           tx_sr_q, rx_sr_q;

    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [AW:0]   tx_cnt_q, rx_cnt_q;

    logic access, wr, rd, sel_ctrl, sel_div, sel_tx, sel_rx, sel_stat;
    logic tx_full, tx_empty, rx_full, rx_empty, tx_push, tx_pop, rx_push, rx_pop;
    logic tick, last_edge, load, done_set, busy, cpha_e, lsbf_e;
    logic shift_ev, mosi_ev, samp_ev;
    logic [7:0] tx_head;
    logic unused_pwdata;

    assign access   = PSEL & PENABLE;
    assign wr       = access & PWRITE;
    assign rd       = access & ~PWRITE;
    assign sel_ctrl = PADDR == 8'h00;
    assign sel_div  = PADDR == 8'h04;
    assign sel_tx   = PADDR == 8'h08;
    assign sel_rx   = PADDR == 8'h0C;
    assign sel_stat = PADDR == 8'h10;
    assign unused_pwdata = &{1'b0, PWDATA};

    assign tx_full  = tx_cnt_q == FULL_CNT;
    assign tx_empty = tx_cnt_q == '0;
    assign rx_full  = rx_cnt_q == FULL_CNT;
    assign rx_empty = rx_cnt_q == '0;
    assign tx_push  = wr & sel_tx & ~tx_full;
    assign rx_pop   = rd & sel_rx & ~rx_empty;
    // A pop in the same cycle frees the slot, so a full RX FIFO can still accept
    assign rx_push  = rx_push_q & (~rx_full | rx_pop);
    assign tx_head  = tx_mem_q[tx_rp_q];

    assign busy      = state_q != S_IDLE;
    assign tick      = cnt_q == div_l_q;
    assign last_edge = edge_q == 4'd15;
    assign cpha_e    = busy ? cpha_l_q : ctrl_q[2];
    assign lsbf_e    = busy ? lsbf_l_q : ctrl_q[4];
    assign shift_ev  = (state_q == S_SHIFT) & tick;
    // Even edge index = leading edge; CPHA selects which edge kind drives vs samples
    assign mosi_ev   = shift_ev & (edge_q[0] != cpha_l_q) & ~last_edge;
    assign samp_ev   = shift_ev & (edge_q[0] == cpha_l_q);

    assign PREADY      = 1'b1;
    assign SCK         = busy ? sck_q : ctrl_q[1];
    assign NSS         = nss_q;
    assign MOSI        = mosi_q;
    assign IRQ_request = irq_q;

    function automatic logic obit(input logic [7:0] b, input logic lsbf);
        return lsbf ? b[0] : b[7];
    endfunction

    function automatic logic [7:0] shf(input logic [7:0] b, input logic lsbf);
        return lsbf ? {1'b0, b[7:1]} : {b[6:0], 1'b0};
    endfunction

    always_comb begin
        state_d  = state_q;
        tx_pop   = 1'b0;
        load     = 1'b0;
        done_set = 1'b0;
        case (state_q)
            S_IDLE: if (ctrl_q[0] && !tx_empty) begin
                state_d = S_LEAD;
                tx_pop  = 1'b1;
                load    = 1'b1;
            end
            S_LEAD: if (tick) state_d = S_SHIFT;
            S_SHIFT: if (tick && last_edge) begin
                if (ctrl_q[0] && !tx_empty) begin
                    tx_pop = 1'b1;
                    load   = 1'b1;
                end else begin
                    state_d = S_LAG;
                end
            end
            S_LAG: if (tick) begin
                state_d  = S_IDLE;
                done_set = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl_d = ctrl_q;
        div_d  = div_q;
        if (wr && sel_ctrl) ctrl_d = PWDATA[4:0];
        if (wr && sel_div)  div_d  = PWDATA[DIV_WIDTH-1:0];
        done_d = done_set | (done_q & ~(wr & sel_stat & PWDATA[5]));
        ovr_d  = (rx_push_q & rx_full & ~rx_pop) | (ovr_q & ~(wr & sel_stat & PWDATA[6]));
    end

    always_comb begin
        PRDATA  = '0;
        PSLVERR = 1'b0;
        if (access && PRESETN) begin
            case (PADDR)
                8'h00: if (!PWRITE) PRDATA[4:0] = ctrl_q;
                8'h04: if (!PWRITE) PRDATA[DIV_WIDTH-1:0] = div_q;
                8'h08: if (PWRITE && tx_full) PSLVERR = 1'b1;
                8'h0C: if (!PWRITE) begin
                    if (rx_empty) PSLVERR = 1'b1;
                    else          PRDATA[7:0] = rx_mem_q[rx_rp_q];
                end
                8'h10: if (!PWRITE)
                    PRDATA[6:0] = {ovr_q, done_q, rx_empty, rx_full, tx_empty, tx_full, busy};
                default: PSLVERR = 1'b1;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            div_q     <= '0;
            div_l_q   <= '0;
            cnt_q     <= '0;
            cpol_l_q  <= 1'b0;
            cpha_l_q  <= 1'b0;
            lsbf_l_q  <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            irq_q     <= 1'b0;
            sck_q     <= 1'b0;
            nss_q     <= 1'b1;
            mosi_q    <= 1'b0;
            rx_push_q <= 1'b0;
            edge_q    <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tx_mem_q[i] <= '0;
                rx_mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            div_q   <= div_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            irq_q   <= ctrl_d[3] & (done_d | ovr_d);

            if (!busy) begin
                cnt_q  <= '0;
                edge_q <= '0;
            end else begin
                cnt_q <= tick ? '0 : cnt_q + DIV_WIDTH'(1);
            end
            // Mode and divider are frozen for the whole burst
            if (load && !busy) begin
                cpol_l_q <= ctrl_q[1];
                cpha_l_q <= ctrl_q[2];
                lsbf_l_q <= ctrl_q[4];
                div_l_q  <= div_q;
                sck_q    <= ctrl_q[1];
                nss_q    <= 1'b0;
            end
            if (shift_ev) begin
                sck_q  <= ~sck_q;
                edge_q <= edge_q + 4'd1;
            end
            if (state_q == S_LAG && tick) nss_q <= 1'b1;

            if (load) begin
                tx_sr_q <= cpha_e ? tx_head : shf(tx_head, lsbf_e);
                if (!cpha_e) mosi_q <= obit(tx_head, lsbf_e);
            end else if (mosi_ev) begin
                mosi_q  <= obit(tx_sr_q, lsbf_l_q);
                tx_sr_q <= shf(tx_sr_q, lsbf_l_q);
            end
            if (samp_ev)
                rx_sr_q <= lsbf_l_q ? {MISO, rx_sr_q[7:1]} : {rx_sr_q[6:0], MISO};
            rx_push_q <= samp_ev & (edge_q[3:1] == 3'd7);

            if (tx_push) begin
                tx_mem_q[tx_wp_q] <= PWDATA[7:0];
                tx_wp_q           <= tx_wp_q + AW'(1);
            end
            if (tx_pop) tx_rp_q <= tx_rp_q + AW'(1);
            tx_cnt_q <= tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);

            if (rx_push) begin
                rx_mem_q[rx_wp_q] <= rx_sr_q;
                rx_wp_q           <= rx_wp_q + AW'(1);
            end
            if (rx_pop) rx_rp_q <= rx_rp_q + AW'(1);
            rx_cnt_q <= rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
        end
    end
endmodule

// File: tb/tb_apb_spi_prog_master.sv
// Directed bench for apb_spi_prog_master: register/error vector table plus
// hand-written SPI burst, overrun and mid-transfer reset sequences (MISO looped to MOSI).
module tb_apb_spi_prog_master;
    localparam int DEPTH = 8;

    logic        PCLK, PRESETN, PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR, IRQ_request, MISO, MOSI, SCK, NSS;

    int checks = 0;
    int errors = 0;

    assign MISO = MOSI;

    apb_spi_prog_master #(.APB_WIDTH(32), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(8)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .IRQ_request(IRQ_request), .MISO(MISO), .MOSI(MOSI), .SCK(SCK), .NSS(NSS)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;
    vec_t vt[$];

    function automatic void add(input bit w, input logic [7:0] a, input logic [31:0] d,
                                input logic [31:0] e, input bit er);
        vec_t v;
        v.wr = w; v.addr = a; v.wdata = d; v.exp_rd = e; v.exp_err = er;
        vt.push_back(v);
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apb(input bit w, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] rdata, output logic err);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        rdata = PRDATA;
        err   = PSLVERR;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] r; logic e;
        apb(1'b1, a, d, r, e);
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] r);
        logic e;
        apb(1'b0, a, 32'h0, r, e);
    endtask

    task automatic do_reset();
        @(negedge PCLK);
        PRESETN = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESETN = 1'b1;
    endtask

    // Watches one NSS-low window; records leading-edge count, leading-edge spacing
    // and MOSI at each sampling edge in arrival order.
    task automatic spi_mon(input logic cpol, input logic cpha, input int maxcyc,
                           output int pulses, output int pmin, output int pmax,
                           output logic [31:0] bits);
        logic prev;
        bit   started;
        int   last;
        pulses = 0; pmin = 1000; pmax = 0; bits = '0; started = 0; last = -1;
        prev = SCK;
        for (int c = 0; c < maxcyc; c++) begin
            @(negedge PCLK);
            if (!started && !NSS) started = 1;
            if (started && NSS) return;
            if (started && SCK != prev) begin
                if (SCK != cpol) begin
                    pulses++;
                    if (last >= 0) begin
                        if (c - last < pmin) pmin = c - last;
                        if (c - last > pmax) pmax = c - last;
                    end
                    last = c;
                end
                if ((SCK != cpol) == !cpha) bits = {bits[30:0], MOSI};
            end
            prev = SCK;
        end
        checks++;
        errors++;
        $display("FAIL spi_mon_timeout: got no NSS release within %0d cycles, expected a complete burst", maxcyc);
    endtask

    initial begin
        logic [31:0] r, bits;
        logic        e;
        int          pulses, pmin, pmax, rises;
        bit          quiet;

        PRESETN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        #12;
        chk("rst_nss", NSS, 1);
        chk("rst_sck", SCK, 0);
        chk("rst_mosi", MOSI, 0);
        chk("rst_irq", IRQ_request, 0);
        chk("rst_prdata", PRDATA, 0);
        chk("rst_pslverr", PSLVERR, 0);
        chk("pready", PREADY, 1);
        @(negedge PCLK);
        PRESETN = 1'b1;

        // Register map, error responses and TX FIFO fill with EN=0
        add(0, 8'h10, 0, 32'h14, 0);
        add(1, 8'h04, 32'h101, 0, 0);
        add(0, 8'h04, 0, 32'h01, 0);
        add(1, 8'h00, 32'hFFFF_FF1E, 0, 0);
        add(0, 8'h00, 0, 32'h1E, 0);
        add(1, 8'h00, 32'h0, 0, 0);
        add(0, 8'h00, 0, 32'h00, 0);
        add(0, 8'h14, 0, 32'h0, 1);
        add(1, 8'h14, 32'h55, 0, 1);
        add(0, 8'h0C, 0, 32'h0, 1);
        add(0, 8'h02, 0, 32'h0, 1);
        add(0, 8'h08, 0, 32'h0, 0);
        for (int i = 0; i < DEPTH; i++) add(1, 8'h08, 32'h10 + i, 0, 0);
        add(1, 8'h08, 32'hEE, 0, 1);
        add(0, 8'h10, 0, 32'h12, 0);
        foreach (vt[i]) begin
            apb(vt[i].wr, vt[i].addr, vt[i].wdata, r, e);
            chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vt[i].exp_err});
            if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), r, vt[i].exp_rd);
        end

        // Mode 0, DIV=1, single byte
        do_reset();
        wr(8'h04, 1);
        wr(8'h08, 32'hA5);
        wr(8'h00, 32'h01);
        spi_mon(1'b0, 1'b0, 300, pulses, pmin, pmax, bits);
        chk("m0_pulses", pulses, 8);
        chk("m0_period_min", pmin, 4);
        chk("m0_period_max", pmax, 4);
        chk("m0_mosi", bits, 32'hA5);
        chk("m0_sck_idle", SCK, 0);
        rd(8'h10, r);
        chk("m0_status", r, 32'h24);
        rd(8'h0C, r);
        chk("m0_rxdata", r, 32'hA5);
        rd(8'h10, r);
        chk("m0_status_after_pop", r, 32'h34);

        // CPOL=1 CPHA=1 LSBF=1, three back-to-back bytes at DIV=0
        do_reset();
        wr(8'h00, 32'h16);
        wr(8'h08, 32'h3C);
        wr(8'h08, 32'h81);
        wr(8'h08, 32'h5E);
        chk("m3_sck_idle_pre", SCK, 1);
        wr(8'h00, 32'h17);
        spi_mon(1'b1, 1'b1, 300, pulses, pmin, pmax, bits);
        chk("m3_pulses", pulses, 24);
        chk("m3_period_min", pmin, 2);
        chk("m3_period_max", pmax, 2);
        chk("m3_mosi", bits, {8'h00, rev8(8'h3C), rev8(8'h81), rev8(8'h5E)});
        chk("m3_sck_idle_post", SCK, 1);
        rd(8'h0C, r);
        chk("m3_rx0", r, 32'h3C);
        rd(8'h0C, r);
        chk("m3_rx1", r, 32'h81);
        rd(8'h0C, r);
        chk("m3_rx2", r, 32'h5E);

        // DEPTH+1 bytes with no RX reads: overrun and interrupt, then W1C
        do_reset();
        for (int i = 0; i < DEPTH; i++) wr(8'h08, 32'h40 + i);
        wr(8'h00, 32'h09);
        wr(8'h08, 32'h99);
        for (int i = 0; i < 200; i++) begin
            rd(8'h10, r);
            if (!r[0]) break;
        end
        chk("ovr_busy_clear", r[0], 0);
        rd(8'h10, r);
        chk("ovr_status", r, 32'h6C);
        chk("ovr_irq", IRQ_request, 1);
        wr(8'h10, 32'h60);
        chk("ovr_irq_cleared", IRQ_request, 0);
        rd(8'h10, r);
        chk("ovr_status_cleared", r, 32'h0C);
        rd(8'h0C, r);
        chk("ovr_rx_first", r, 32'h40);

        // Reset in the middle of bit 4
        do_reset();
        wr(8'h04, 3);
        wr(8'h08, 32'hFF);
        wr(8'h00, 32'h01);
        rises = 0;
        for (int c = 0; c < 400 && rises < 4; c++) begin
            logic p;
            p = SCK;
            @(negedge PCLK);
            if (!p && SCK) rises++;
        end
        chk("rst_mid_reached_bit4", rises, 4);
        chk("rst_mid_pre_nss", NSS, 0);
        #2;
        PRESETN = 1'b0;
        #1;
        chk("rst_mid_nss", NSS, 1);
        chk("rst_mid_sck", SCK, 0);
        chk("rst_mid_mosi", MOSI, 0);
        quiet = 1;
        repeat (3) begin
            @(negedge PCLK);
            if (SCK !== 1'b0 || NSS !== 1'b1) quiet = 0;
        end
        chk("rst_mid_quiet", {31'b0, quiet}, 1);
        PRESETN = 1'b1;
        rd(8'h10, r);
        chk("rst_mid_status", r, 32'h14);
        rd(8'h00, r);
        chk("rst_mid_ctrl", r, 32'h0);
        repeat (20) @(negedge PCLK);
        chk("rst_mid_nss_stays", NSS, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_spi_prog_master.md
APB_SPI_PROG_MASTER -- requirements
Module: apb_spi_prog_master

Interface
REQ-001 SHALL have parameter APB_WIDTH, default 32: APB data width; must be at least 16.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: entries per TX and RX FIFO; must be a power of 2 and at least 2.
REQ-003 SHALL have parameter DIV_WIDTH, default 8: width of the SCK divider register.
REQ-004 SHALL have these ports, clock and reset first:
- PCLK, in, 1: sole clock; all logic on its rising edge.
- PRESETN, in, 1: asynchronous active-low reset.
- PSEL, PENABLE, PWRITE, in, 1 each: APB control.
- PADDR, in, 8: byte address.
- PWDATA, in, APB_WIDTH: write data.
- PRDATA, out, APB_WIDTH: read data.
- PREADY, out, 1: always 1.
- PSLVERR, out, 1: error response.
- IRQ_request, out, 1: level interrupt.
- MISO, in, 1: SPI data in.
- MOSI, out, 1: SPI data out.
- SCK, out, 1: SPI clock.
- NSS, out, 1: active-low slave select.

Function
REQ-005 SHALL decode this register map; unused PRDATA bits read 0:
- 0x00 CTRL, RW: bit0 EN, bit1 CPOL, bit2 CPHA, bit3 IRQEN, bit4 LSBF.
- 0x04 DIV, RW: DIV_WIDTH bits.
- 0x08 TXDATA, W: bits[7:0] push to TX FIFO.
- 0x0C RXDATA, R: pop from RX FIFO; data in bits[7:0].
- 0x10 STATUS: bit0 BUSY, bit1 TXFULL, bit2 TXEMPTY, bit3 RXFULL, bit4 RXEMPTY, bit5 DONE (W1C), bit6 OVR (W1C).
REQ-006 SHALL complete every APB access in the access phase (PSEL&PENABLE) with zero wait states.
REQ-007 SHALL assert PSLVERR only during the access phase, for any of:
- an unmapped address;
- a TXDATA write while TX FIFO is full (data discarded);
- a RXDATA read while RX FIFO is empty (PRDATA=0, no pop).
REQ-008 SHALL update FIFO state and registers on the access-phase clock edge. A simultaneous push and pop on one FIFO SHALL leave its count unchanged.
REQ-009 SHALL keep SCK half-period = DIV+1 PCLK cycles; DIV=0 gives SCK = PCLK/2.
REQ-010 SHALL drive SCK=CPOL whenever not in SHIFT.
REQ-011 SHALL run this FSM:
- IDLE: leave when EN=1 and TX FIFO not empty -> LEAD, popping one byte into the shift register and driving NSS low.
- LEAD: wait one half-period -> SHIFT.
- SHIFT: 16 SCK edges, 8 bits.
- After the 8th bit: if TX FIFO not empty and EN=1, pop the next byte and go back to SHIFT with no gap, NSS held low; otherwise -> LAG.
- LAG: wait one half-period, drive NSS high, set DONE -> IDLE.
REQ-012 SHALL obey SPI mode rules:
- CPHA=0: MOSI valid from LEAD; sample MISO on leading edges; shift MOSI on trailing edges.
- CPHA=1: shift MOSI on leading edges; sample on trailing edges.
- Bit order is MSB first unless LSBF=1.
REQ-013 SHALL push each completed received byte to the RX FIFO on the cycle after the 8th sample. If the RX FIFO is full, the byte is dropped and OVR is set.
REQ-014 SHALL latch CPOL, CPHA, LSBF and DIV on leaving IDLE; CTRL/DIV writes while BUSY take effect at the next burst.
REQ-015 SHALL, on clearing EN mid-byte, finish the current byte, then go to LAG; remaining TX entries are retained.
REQ-016 SHALL drive BUSY=1 in every state except IDLE.
REQ-017 SHALL drive IRQ_request = IRQEN & (DONE | OVR), registered.
REQ-018 SHALL give hardware set priority over a same-cycle W1C clear of DONE or OVR.

Reset
REQ-019 SHALL, while PRESETN=0, force:
- FSM to IDLE;
- all registers and flags to 0, FIFOs empty;
- SCK=0, MOSI=0, NSS=1, IRQ_request=0, PRDATA=0, PSLVERR=0.
REQ-020 SHALL, on a reset mid-transfer, release NSS high immediately (asynchronously) with no further SCK edges.

Verification
REQ-021 SHALL pass each of these bench scenarios:
- Mode 0, DIV=1, MISO looped to MOSI: write 0xA5, EN=1 -> SCK period 4 PCLK, 8 pulses, MOSI MSB-first, RXDATA=0xA5, DONE=1.
- CPOL=1, CPHA=1, LSBF=1: 3 TX bytes queued -> NSS low continuously for 24 bits with no gap, idle SCK=1, 3 RX bytes in order.
- FIFO_DEPTH+1 TXDATA writes with EN=0 -> last write PSLVERR=1, TXFULL=1; RXDATA read while empty -> PSLVERR=1, PRDATA=0.
- FIFO_DEPTH+1 bytes transferred without reading RX -> OVR=1; with IRQEN=1, IRQ_request=1; W1C of OVR and DONE -> IRQ_request=0 next cycle.
- PRESETN pulsed low at bit 4 -> NSS=1 and SCK=CPOL within the same cycle; all STATUS bits reset.
- Read address 0x14 -> PSLVERR=1, PRDATA=0.
